issue_buffer: RTL and testbench

- Circular instruction queue between decode and the dual-issue EX launch stage.
- Accepts up to two decoded PC_set entries per cycle from decode.
- Presents the two oldest entries as o_set1/o_set2 with o_valid, which the issue stage consumes.
- Decides single vs dual issue from pairing and RAW rules, pops what was presented when not stalled, and clears on branch flush.

---
 rtl/issue_buffer_pkg.sv | 28 ++
 rtl/issue_buffer_pair_check.sv | 12 +
 rtl/issue_buffer.sv | 89 ++++++++
 tb/tb_issue_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_buffer_pkg.sv
// Shared decode/issue types plus the dual-issue pairing rule used by the issue buffer.
package Public_Info;

    localparam logic [9:0] INST_TYPE_ALU = 10'h001;

    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  inst_type;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic        o_valid;
    } PC_set;

    // h0 is the older instruction; h1 may only issue with it when no hazard exists.
    function automatic logic pair_ok(input PC_set h0, input PC_set h1);
        logic pairing;
        logic raw;
        logic waw;
        pairing = (h0.inst_type == INST_TYPE_ALU) || (h1.inst_type == INST_TYPE_ALU);
        raw     = h0.rf_we && (h0.rf_rd != '0) &&
                  ((h1.rf_raddr1 == h0.rf_rd) || (h1.rf_raddr2 == h0.rf_rd));
        waw     = h0.rf_we && h1.rf_we && (h0.rf_rd == h1.rf_rd) && (h0.rf_rd != '0);
        return pairing && !raw && !waw;
    endfunction

endpackage

// File: rtl/issue_buffer_pair_check.sv
// Combinational dual-issue hazard check between the two oldest queue entries.
module issue_pair_check
    import Public_Info::*;
(
    input  PC_set h0,
    input  PC_set h1,
    output logic  pair_ok
);

    assign pair_ok = Public_Info::pair_ok(h0, h1);

endmodule

// File: rtl/issue_buffer.sv
// Circular issue queue: up to two pushes from decode and up to two pops to EX per cycle.
module issue_buffer
    import Public_Info::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rstn,
    input  PC_set        in_set1,
    input  PC_set        in_set2,
    input  logic         in_valid1,
    input  logic         in_valid2,
    input  logic         flush_BR,
    input  logic         stall_DCache,
    output PC_set        o_set1,
    output PC_set        o_set2,
    output logic         buf_ready,
    output logic [PTR_W:0] buf_count
);

    PC_set            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail1;
    logic [PTR_W:0]   count;
    logic             pair_ok_w;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    PC_set            wr0;
    PC_set            wr1;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    issue_pair_check u_pair (
        .h0      (mem[head]),
        .h1      (mem[head1]),
        .pair_ok (pair_ok_w)
    );

    always_comb begin
        o_set1         = mem[head];
        o_set1.o_valid = (count != '0);
        o_set2         = mem[head1];
        o_set2.o_valid = (count >= (PTR_W+1)'(2)) && pair_ok_w;
        buf_ready      = (count <= (PTR_W+1)'(DEPTH - 2));
        buf_count      = count;
    end

    // A lone in_set2 is compacted into the tail slot.
    always_comb begin
        wr0         = in_valid1 ? in_set1 : in_set2;
        wr0.o_valid = 1'b0;
        wr1         = in_set2;
        wr1.o_valid = 1'b0;
        push_n      = '0;
        pop_n       = '0;
        if (buf_ready && !flush_BR)
            push_n = {1'b0, in_valid1} + {1'b0, in_valid2};
        if (!stall_DCache && !flush_BR)
            pop_n = {1'b0, o_set1.o_valid} + {1'b0, o_set2.o_valid};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            mem   <= '{default: '0};
        end else if (flush_BR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_n != 2'd0)
                mem[tail] <= wr0;
            if (push_n == 2'd2)
                mem[tail1] <= wr1;
            tail  <= tail + PTR_W'(push_n);
            head  <= head + PTR_W'(pop_n);
            count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) count <= (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: vector table for issue rules, hand sequences for fill/drain/flush/reset.
module tb_issue_buffer;
    import Public_Info::*;

    logic       clk = 1'b0;
    logic       rstn;
    PC_set      in_set1, in_set2;
    logic       in_valid1, in_valid2;
    logic       flush_BR, stall_DCache;
    PC_set      o_set1, o_set2;
    logic       buf_ready;
    logic [4:0] buf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_buffer #(.DEPTH(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_set1      (in_set1),
        .in_set2      (in_set2),
        .in_valid1    (in_valid1),
        .in_valid2    (in_valid2),
        .flush_BR     (flush_BR),
        .stall_DCache (stall_DCache),
        .o_set1       (o_set1),
        .o_set2       (o_set2),
        .buf_ready    (buf_ready),
        .buf_count    (buf_count)
    );

    typedef struct {
        logic        v1;
        logic        v2;
        PC_set       s1;
        PC_set       s2;
        logic        e_ov1;
        logic        e_ov2;
        logic [31:0] e_pc1;
        logic [31:0] e_pc2;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs [17];

    function automatic PC_set mk(input logic [31:0] pc, input logic [9:0] ty, input logic we,
                                 input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        PC_set s;
        s.pc = pc; s.inst_type = ty; s.rf_we = we; s.rf_rd = rd;
        s.rf_raddr1 = r1; s.rf_raddr2 = r2; s.o_valid = 1'b0;
        return s;
    endfunction

    function automatic vec_t mv(input logic v1, input logic v2, input PC_set s1, input PC_set s2,
                                input logic ov1, input logic ov2, input logic [31:0] pc1,
                                input logic [31:0] pc2, input logic [4:0] cnt);
        vec_t v;
        v.v1 = v1; v.v2 = v2; v.s1 = s1; v.s2 = s2;
        v.e_ov1 = ov1; v.e_ov2 = ov2; v.e_pc1 = pc1; v.e_pc2 = pc2; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v1, input logic v2, input PC_set s1, input PC_set s2);
        in_valid1 = v1; in_valid2 = v2; in_set1 = s1; in_set2 = s2;
    endtask

    PC_set z, ra, rb;

    initial begin
        z = '0;
        vecs[0]  = mv(0, 0, z, z, 0, 0, 0, 0, 0);
        vecs[1]  = mv(1, 1, mk(32'h1c000000, 10'h001, 1, 4, 1, 2), mk(32'h1c000004, 10'h001, 1, 5, 1, 2),
                      1, 1, 32'h1c000000, 32'h1c000004, 2);
        vecs[2]  = mv(0, 0, z, z, 0, 0, 0, 0, 0);
        vecs[3]  = mv(1, 1, mk(32'h1c000010, 10'h001, 1, 6, 3, 0), mk(32'h1c000014, 10'h001, 1, 7, 6, 0),
                      1, 0, 32'h1c000010, 0, 2);
        vecs[4]  = mv(0, 0, z, z, 1, 0, 32'h1c000014, 0, 1);
        vecs[5]  = mv(0, 0, z, z, 0, 0, 0, 0, 0);
        vecs[6]  = mv(1, 1, mk(32'h1c000020, 10'h002, 0, 0, 0, 0), mk(32'h1c000024, 10'h002, 0, 0, 0, 0),
                      1, 0, 32'h1c000020, 0, 2);
        vecs[7]  = mv(1, 1, mk(32'h1c000028, 10'h001, 1, 8, 1, 2), mk(32'h1c00002c, 10'h002, 0, 0, 9, 0),
                      1, 1, 32'h1c000024, 32'h1c000028, 3);
        vecs[8]  = mv(0, 0, z, z, 1, 0, 32'h1c00002c, 0, 1);
        vecs[9]  = mv(0, 0, z, z, 0, 0, 0, 0, 0);
        vecs[10] = mv(0, 1, mk(32'h1c0000ff, 10'h001, 0, 0, 0, 0), mk(32'h1c000008, 10'h001, 1, 1, 0, 0),
                      1, 0, 32'h1c000008, 0, 1);
        vecs[11] = mv(1, 0, mk(32'h1c00000c, 10'h001, 0, 0, 0, 0), z, 1, 0, 32'h1c00000c, 0, 1);
        vecs[12] = mv(0, 0, z, z, 0, 0, 0, 0, 0);
        vecs[13] = mv(1, 1, mk(32'h1c000030, 10'h001, 1, 9, 1, 2), mk(32'h1c000034, 10'h001, 1, 9, 3, 4),
                      1, 0, 32'h1c000030, 0, 2);
        vecs[14] = mv(1, 1, mk(32'h1c000038, 10'h001, 1, 0, 1, 2), mk(32'h1c00003c, 10'h001, 1, 0, 0, 0),
                      1, 1, 32'h1c000034, 32'h1c000038, 3);
        vecs[15] = mv(0, 0, z, z, 1, 0, 32'h1c00003c, 0, 1);
        vecs[16] = mv(0, 0, z, z, 0, 0, 0, 0, 0);

        rstn = 1'b0; flush_BR = 1'b0; stall_DCache = 1'b0;
        drive(0, 0, z, z);
        step(); step();
        chk("rst_ov1", {31'b0, o_set1.o_valid}, 0);
        chk("rst_ov2", {31'b0, o_set2.o_valid}, 0);
        chk("rst_set1", o_set1.pc, 0);
        chk("rst_ready", {31'b0, buf_ready}, 1);
        chk("rst_count", {27'b0, buf_count}, 0);
        rstn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].v1, vecs[i].v2, vecs[i].s1, vecs[i].s2);
            step();
            chk($sformatf("v%0d_ov1", i), {31'b0, o_set1.o_valid}, {31'b0, vecs[i].e_ov1});
            chk($sformatf("v%0d_ov2", i), {31'b0, o_set2.o_valid}, {31'b0, vecs[i].e_ov2});
            if (vecs[i].e_ov1) chk($sformatf("v%0d_pc1", i), o_set1.pc, vecs[i].e_pc1);
            if (vecs[i].e_ov2) chk($sformatf("v%0d_pc2", i), o_set2.pc, vecs[i].e_pc2);
            chk($sformatf("v%0d_cnt", i), {27'b0, buf_count}, {27'b0, vecs[i].e_cnt});
            chk($sformatf("v%0d_rdy", i), {31'b0, buf_ready}, 1);
        end
        drive(0, 0, z, z);

        // Fill under stall from a non-zero head so both pointers wrap.
        stall_DCache = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fill%0d_rdy", k), {31'b0, buf_ready}, 1);
            drive(1, 1, mk(32'h1c000100 + 8 * k, 10'h001, 0, 0, 0, 0),
                        mk(32'h1c000104 + 8 * k, 10'h001, 0, 0, 0, 0));
            step();
            chk($sformatf("fill%0d_cnt", k), {27'b0, buf_count}, 2 * k + 2);
            chk($sformatf("fill%0d_hold", k), o_set1.pc, 32'h1c000100);
        end
        chk("full_rdy", {31'b0, buf_ready}, 0);
        drive(1, 1, mk(32'h1c00ffff, 10'h001, 0, 0, 0, 0), mk(32'h1c00fffb, 10'h001, 0, 0, 0, 0));
        step();
        chk("full_drop_cnt", {27'b0, buf_count}, 16);
        chk("full_hold", o_set1.pc, 32'h1c000100);
        drive(0, 0, z, z);
        stall_DCache = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d_pc1", j), o_set1.pc, 32'h1c000100 + 8 * j);
            chk($sformatf("drain%0d_pc2", j), o_set2.pc, 32'h1c000104 + 8 * j);
            chk($sformatf("drain%0d_ov2", j), {31'b0, o_set2.o_valid}, 1);
            step();
        end
        chk("drain_cnt", {27'b0, buf_count}, 0);

        // count == DEPTH-1 must already refuse pushes.
        stall_DCache = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive(1, 1, mk(32'h1c000300 + 8 * k, 10'h001, 0, 0, 0, 0),
                        mk(32'h1c000304 + 8 * k, 10'h001, 0, 0, 0, 0));
            step();
        end
        drive(1, 0, mk(32'h1c000340, 10'h001, 0, 0, 0, 0), z);
        step();
        chk("cnt15", {27'b0, buf_count}, 15);
        chk("cnt15_rdy", {31'b0, buf_ready}, 0);
        drive(0, 0, z, z);
        flush_BR = 1'b1;
        step();
        flush_BR = 1'b0;
        chk("flush15_cnt", {27'b0, buf_count}, 0);

        // Flush at count 5 while pushing: pushed entries must be discarded.
        drive(1, 1, mk(32'h1c000400, 10'h001, 0, 0, 0, 0), mk(32'h1c000404, 10'h001, 0, 0, 0, 0));
        step(); step();
        drive(1, 0, mk(32'h1c000408, 10'h001, 0, 0, 0, 0), z);
        step();
        chk("pre_flush_cnt", {27'b0, buf_count}, 5);
        stall_DCache = 1'b0;
        flush_BR = 1'b1;
        drive(1, 1, mk(32'h1c00dead, 10'h001, 0, 0, 0, 0), mk(32'h1c00beef, 10'h001, 0, 0, 0, 0));
        step();
        flush_BR = 1'b0;
        drive(0, 0, z, z);
        chk("flush_cnt", {27'b0, buf_count}, 0);
        chk("flush_ov1", {31'b0, o_set1.o_valid}, 0);
        chk("flush_ov2", {31'b0, o_set2.o_valid}, 0);
        chk("flush_rdy", {31'b0, buf_ready}, 1);
        step();
        chk("flush_idle_cnt", {27'b0, buf_count}, 0);
        chk("flush_idle_ov1", {31'b0, o_set1.o_valid}, 0);
        ra = mk(32'h1c000200, 10'h001, 0, 0, 0, 0);
        rb = mk(32'h1c000204, 10'h002, 0, 0, 0, 0);
        drive(1, 1, ra, rb);
        step();
        drive(0, 0, z, z);
        chk("post_flush_pc1", o_set1.pc, 32'h1c000200);
        chk("post_flush_pc2", o_set2.pc, 32'h1c000204);
        chk("post_flush_ov2", {31'b0, o_set2.o_valid}, 1);
        chk("post_flush_cnt", {27'b0, buf_count}, 2);

        // Reset mid-operation clears pointers and storage.
        stall_DCache = 1'b1;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        stall_DCache = 1'b0;
        chk("mid_rst_cnt", {27'b0, buf_count}, 0);
        chk("mid_rst_ov1", {31'b0, o_set1.o_valid}, 0);
        chk("mid_rst_mem", o_set1.pc, 0);
        chk("mid_rst_rdy", {31'b0, buf_ready}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
